pcie_sq_tx_req: RTL and testbench

PCIE_SQ_TX_REQ -- requirements
Module: pcie_sq_tx_req

---
 rtl/pcie_sq_tx_req.sv | 139 +++++++++++++
 tb/tb_pcie_sq_tx_req.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_sq_tx_req.sv
// Splits a submission-queue fetch into tagged PCIe memory-read requests gated by tag and FIFO space.
// Define PCIE_SQ_TX_REQ_4KB_SPLIT_EN to keep every request inside one 4 KB address page.
module pcie_sq_tx_req #(
   parameter int unsigned C_PCIE_DATA_WIDTH  = 512,
   parameter int unsigned C_PCIE_ADDR_WIDTH  = 36,
   parameter int unsigned P_FIFO_DEPTH_WIDTH = 4,
   parameter int unsigned P_MAX_REQ_BEATS    = 2
) (
   input  logic                            pcie_user_clk,
   input  logic                            pcie_user_rst,
   input  logic                            sq_fetch_req,
   input  logic [C_PCIE_ADDR_WIDTH-7:0]    sq_fetch_addr,
   input  logic [P_FIFO_DEPTH_WIDTH:0]     sq_fetch_len,
   output logic                            sq_fetch_ack,
   output logic                            sq_fetch_done,
   output logic                            tx_mrd_req,
   output logic [C_PCIE_ADDR_WIDTH-3:0]    tx_mrd_addr,
   output logic [9:0]                      tx_mrd_len,
   output logic [7:0]                      tx_mrd_tag,
   input  logic                            tx_mrd_req_ack,
   output logic                            pcie_tag_alloc,
   output logic [7:0]                      pcie_alloc_tag,
   output logic [P_FIFO_DEPTH_WIDTH:0]     pcie_tag_alloc_len,
   input  logic                            pcie_tag_full_n,
   input  logic [P_FIFO_DEPTH_WIDTH:0]     rear_full_addr,
   input  logic [P_FIFO_DEPTH_WIDTH:0]     front_addr
);

   localparam int unsigned DwPerBeat = C_PCIE_DATA_WIDTH / 32;
   localparam int unsigned LenW      = P_FIFO_DEPTH_WIDTH + 1;
   localparam int unsigned BeatAddrW = C_PCIE_ADDR_WIDTH - 6;
   localparam int unsigned FifoDepth = 1 << P_FIFO_DEPTH_WIDTH;
`ifdef PCIE_SQ_TX_REQ_4KB_SPLIT_EN
   localparam int unsigned BeatBytes = C_PCIE_DATA_WIDTH / 8;
   localparam int unsigned Beats4k   = 4096 / BeatBytes;
   localparam int unsigned Beats4kW  = $clog2(Beats4k);
`endif

   typedef enum logic [1:0] {StIdle, StCalc, StWait, StReq} state_e;

   state_e               state_q;
   logic [BeatAddrW-1:0] addr_q;
   logic [LenW-1:0]      rem_q;
   logic [LenW-1:0]      chunk_q;
   logic [2:0]           tag_cnt_q;

   logic [31:0]          chunk_lim;
   logic [LenW-1:0]      chunk_calc;
   logic [LenW-1:0]      fifo_used;
   logic [LenW:0]        fifo_need;
   logic                 fifo_fits;

   always_comb begin
      chunk_lim = P_MAX_REQ_BEATS;
      if (32'(rem_q) < chunk_lim) begin
         chunk_lim = 32'(rem_q);
      end
`ifdef PCIE_SQ_TX_REQ_4KB_SPLIT_EN
      // Beats left before the next 4 KB page starts.
      if (Beats4k - 32'(addr_q[Beats4kW-1:0]) < chunk_lim) begin
         chunk_lim = Beats4k - 32'(addr_q[Beats4kW-1:0]);
      end
`endif
      chunk_calc = LenW'(chunk_lim);
   end

   // used + chunk <= depth is free >= chunk without a signed free term.
   always_comb begin
      fifo_used = rear_full_addr - front_addr;
      fifo_need = {1'b0, fifo_used} + {1'b0, chunk_q};
      fifo_fits = 32'(fifo_need) <= FifoDepth;
   end

   always_ff @(posedge pcie_user_clk) begin
      if (pcie_user_rst) begin
         state_q            <= StIdle;
         addr_q             <= '0;
         rem_q              <= '0;
         chunk_q            <= '0;
         tag_cnt_q          <= '0;
         sq_fetch_ack       <= 1'b0;
         sq_fetch_done      <= 1'b0;
         tx_mrd_req         <= 1'b0;
         tx_mrd_addr        <= '0;
         tx_mrd_len         <= '0;
         tx_mrd_tag         <= '0;
         pcie_tag_alloc     <= 1'b0;
         pcie_alloc_tag     <= '0;
         pcie_tag_alloc_len <= '0;
      end else begin
         sq_fetch_ack   <= 1'b0;
         sq_fetch_done  <= 1'b0;
         pcie_tag_alloc <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (sq_fetch_req) begin
                  addr_q       <= sq_fetch_addr;
                  rem_q        <= sq_fetch_len;
                  sq_fetch_ack <= 1'b1;
                  state_q      <= StCalc;
               end
            end
            StCalc: begin
               if (rem_q == '0) begin
                  sq_fetch_done <= 1'b1;
                  state_q       <= StIdle;
               end else begin
                  chunk_q <= chunk_calc;
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (pcie_tag_full_n && fifo_fits) begin
                  pcie_tag_alloc     <= 1'b1;
                  pcie_alloc_tag     <= {5'b00000, tag_cnt_q};
                  pcie_tag_alloc_len <= chunk_q;
                  tx_mrd_req         <= 1'b1;
                  tx_mrd_addr        <= {addr_q, 4'b0000};
                  // 1024 DW truncates to 0, which is the PCIe encoding for 1024.
                  tx_mrd_len         <= 10'(32'(chunk_q) * DwPerBeat);
                  tx_mrd_tag         <= {5'b00000, tag_cnt_q};
                  state_q            <= StReq;
               end
            end
            StReq: begin
               if (tx_mrd_req_ack) begin
                  tx_mrd_req <= 1'b0;
                  addr_q     <= addr_q + BeatAddrW'(chunk_q);
                  rem_q      <= rem_q - chunk_q;
                  tag_cnt_q  <= tag_cnt_q + 3'd1;
                  state_q    <= StCalc;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pcie_sq_tx_req.sv
// Bench for pcie_sq_tx_req: fixed vectors, hand-written stall/reset sequences, randomized commands.
module tb_pcie_sq_tx_req;

   localparam int unsigned DW   = 512;
   localparam int unsigned AW   = 36;
   localparam int unsigned FW   = 4;
   localparam int unsigned MAXB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            sq_fetch_req;
   logic [AW-7:0]   sq_fetch_addr;
   logic [FW:0]     sq_fetch_len;
   logic            sq_fetch_ack;
   logic            sq_fetch_done;
   logic            tx_mrd_req;
   logic [AW-3:0]   tx_mrd_addr;
   logic [9:0]      tx_mrd_len;
   logic [7:0]      tx_mrd_tag;
   logic            tx_mrd_req_ack;
   logic            pcie_tag_alloc;
   logic [7:0]      pcie_alloc_tag;
   logic [FW:0]     pcie_tag_alloc_len;
   logic            pcie_tag_full_n;
   logic [FW:0]     rear_full_addr;
   logic [FW:0]     front_addr;

   pcie_sq_tx_req #(
      .C_PCIE_DATA_WIDTH  (DW),
      .C_PCIE_ADDR_WIDTH  (AW),
      .P_FIFO_DEPTH_WIDTH (FW),
      .P_MAX_REQ_BEATS    (MAXB)
   ) dut (
      .pcie_user_clk      (clk),
      .pcie_user_rst      (rst),
      .sq_fetch_req       (sq_fetch_req),
      .sq_fetch_addr      (sq_fetch_addr),
      .sq_fetch_len       (sq_fetch_len),
      .sq_fetch_ack       (sq_fetch_ack),
      .sq_fetch_done      (sq_fetch_done),
      .tx_mrd_req         (tx_mrd_req),
      .tx_mrd_addr        (tx_mrd_addr),
      .tx_mrd_len         (tx_mrd_len),
      .tx_mrd_tag         (tx_mrd_tag),
      .tx_mrd_req_ack     (tx_mrd_req_ack),
      .pcie_tag_alloc     (pcie_tag_alloc),
      .pcie_alloc_tag     (pcie_alloc_tag),
      .pcie_tag_alloc_len (pcie_tag_alloc_len),
      .pcie_tag_full_n    (pcie_tag_full_n),
      .rear_full_addr     (rear_full_addr),
      .front_addr         (front_addr)
   );

   typedef struct packed {
      logic [AW-3:0] addr;
      logic [9:0]    len;
      logic [7:0]    tag;
   } req_t;

   typedef struct packed {
      logic [7:0] tag;
      logic [FW:0] len;
   } alloc_t;

   typedef struct packed {
      logic [35:0]       abyte;
      logic [4:0]        len;
      logic [1:0]        n;
      logic [2:0][35:0]  eaddr;
      logic [2:0][9:0]   elen;
      logic [2:0][2:0]   etag;
   } vec_t;

   int     checks   = 0;
   int     failures = 0;
   int     ack_mode = 1;   // 0 withhold, 1 always, 2 random
   bit     rand_mode = 1'b0;
   int     done_cnt = 0;
   int     done_base = 0;
   int     cyc = 0;
   int     last_alloc = 0;
   bit     last_valid = 1'b0;
   bit     pend = 1'b0;
   req_t   held;
   logic   prev_full_n = 1'b0;
   int     prev_free = 0;
   logic [FW:0] used_v;
   logic [2:0]  mtag = 3'd0;

   req_t   obs_q[$];
   req_t   exp_q[$];
   alloc_t alloc_q[$];
   vec_t   vecs[3];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: walk the fetch in chunks using the splitting rules directly.
   task automatic model_split(input logic [35:0] abyte, input int unsigned len);
      longint unsigned a;
      longint unsigned b;
      int unsigned     rem;
      int unsigned     c;
      req_t            r;
      a   = longint'(abyte) / 64;
      rem = len;
      while (rem > 0) begin
         c = (rem < MAXB) ? rem : MAXB;
`ifdef PCIE_SQ_TX_REQ_4KB_SPLIT_EN
         b = 64 - (a % 64);
         if (b < longint'(c)) c = int'(b);
`else
         b = 0;
`endif
         r.addr = (AW-2)'(a * 16);
         r.len  = 10'((c * 16) % 1024);
         r.tag  = {5'b00000, mtag};
         exp_q.push_back(r);
         a    = a + c;
         rem  = rem - c;
         mtag = mtag + 3'd1;
      end
   endtask

   always begin
      @(posedge clk);
      #2;
      case (ack_mode)
         0:       tx_mrd_req_ack = 1'b0;
         1:       tx_mrd_req_ack = 1'b1;
         default: tx_mrd_req_ack = ($urandom_range(0, 2) == 0);
      endcase
      if (rand_mode) begin
         pcie_tag_full_n = ($urandom_range(0, 3) != 0);
         front_addr      = (FW+1)'($urandom);
         rear_full_addr  = front_addr + (FW+1)'($urandom_range(0, 16));
      end
   end

   always @(negedge clk) begin
      alloc_t at;
      req_t   rq;
      cyc++;
      if (rst) begin
         last_valid = 1'b0;
         pend       = 1'b0;
      end else begin
         if (pcie_tag_alloc) begin
            at.tag = pcie_alloc_tag;
            at.len = pcie_tag_alloc_len;
            alloc_q.push_back(at);
            check("alloc_tag_free", 64'(prev_full_n), 64'd1);
            check("alloc_fifo_room", 64'(prev_free >= int'(pcie_tag_alloc_len)), 64'd1);
            if (last_valid) check("alloc_spacing", 64'((cyc - last_alloc) >= 3), 64'd1);
            last_alloc = cyc;
            last_valid = 1'b1;
         end
         rq.addr = tx_mrd_addr;
         rq.len  = tx_mrd_len;
         rq.tag  = tx_mrd_tag;
         if (tx_mrd_req && pend) check("req_stable", 64'(rq), 64'(held));
         if (tx_mrd_req && tx_mrd_req_ack) obs_q.push_back(rq);
         pend = tx_mrd_req && !tx_mrd_req_ack;
         held = rq;
         if (sq_fetch_done) done_cnt++;
      end
      prev_full_n = pcie_tag_full_n;
      used_v      = rear_full_addr - front_addr;
      prev_free   = (1 << FW) - int'(used_v);
   end

   task automatic clear_all();
      obs_q.delete();
      exp_q.delete();
      alloc_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      sq_fetch_req = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      mtag = 3'd0;
      @(negedge clk);
      clear_all();
   endtask

   task automatic start_cmd(input logic [35:0] abyte, input int unsigned len);
      done_base = done_cnt;
      @(posedge clk);
      #2;
      sq_fetch_req  = 1'b1;
      sq_fetch_addr = abyte[35:6];
      sq_fetch_len  = (FW+1)'(len);
      @(negedge clk);
      check("ack_early", 64'(sq_fetch_ack), 64'd0);
      @(posedge clk);
      #2;
      sq_fetch_req  = 1'b0;
      sq_fetch_addr = (AW-6)'($urandom);
      sq_fetch_len  = (FW+1)'($urandom);
      @(negedge clk);
      check("fetch_ack", 64'(sq_fetch_ack), 64'd1);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == done_base && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 64'(done_cnt != done_base), 64'd1);
      if (done_cnt == done_base) begin
         do_reset();
         done_base = done_cnt - 1;
      end else begin
         repeat (3) @(negedge clk);
         check("done_once", 64'(done_cnt - done_base), 64'd1);
      end
   endtask

   task automatic compare_model();
      check("req_count", 64'(obs_q.size()), 64'(exp_q.size()));
      check("alloc_count", 64'(alloc_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs_q.size()) begin
            check("req_addr", 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            check("req_len", 64'(obs_q[i].len), 64'(exp_q[i].len));
            check("req_tag", 64'(obs_q[i].tag), 64'(exp_q[i].tag));
         end
         if (i < alloc_q.size()) begin
            check("alloc_tag", 64'(alloc_q[i].tag), 64'(exp_q[i].tag));
            check("alloc_len", 64'(10'(alloc_q[i].len * 16)), 64'(exp_q[i].len));
         end
      end
      clear_all();
   endtask

   initial begin
      #900000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [29:0] beat;
      int unsigned len;
      bit seen;

      rst = 1'b1;
      sq_fetch_req = 1'b0;
      sq_fetch_addr = '0;
      sq_fetch_len = '0;
      pcie_tag_full_n = 1'b1;
      rear_full_addr = '0;
      front_addr = '0;
      tx_mrd_req_ack = 1'b1;

      vecs[0] = '0;
      vecs[0].abyte = 36'h10000; vecs[0].len = 5'd5; vecs[0].n = 2'd3;
      vecs[0].eaddr[0] = 36'h10000; vecs[0].elen[0] = 10'd32; vecs[0].etag[0] = 3'd0;
      vecs[0].eaddr[1] = 36'h10080; vecs[0].elen[1] = 10'd32; vecs[0].etag[1] = 3'd1;
      vecs[0].eaddr[2] = 36'h10100; vecs[0].elen[2] = 10'd16; vecs[0].etag[2] = 3'd2;
      vecs[1] = '0;
      vecs[1].abyte = 36'h0FC0; vecs[1].len = 5'd3; vecs[1].n = 2'd2;
`ifdef PCIE_SQ_TX_REQ_4KB_SPLIT_EN
      vecs[1].eaddr[0] = 36'h0FC0; vecs[1].elen[0] = 10'd16; vecs[1].etag[0] = 3'd3;
      vecs[1].eaddr[1] = 36'h1000; vecs[1].elen[1] = 10'd32; vecs[1].etag[1] = 3'd4;
`else
      vecs[1].eaddr[0] = 36'h0FC0; vecs[1].elen[0] = 10'd32; vecs[1].etag[0] = 3'd3;
      vecs[1].eaddr[1] = 36'h1040; vecs[1].elen[1] = 10'd16; vecs[1].etag[1] = 3'd4;
`endif
      vecs[2] = '0;
      vecs[2].abyte = 36'h2000; vecs[2].len = 5'd0; vecs[2].n = 2'd0;

      repeat (3) @(negedge clk);
      check("rst_ack", 64'(sq_fetch_ack), 64'd0);
      check("rst_done", 64'(sq_fetch_done), 64'd0);
      check("rst_req", 64'(tx_mrd_req), 64'd0);
      check("rst_addr", 64'(tx_mrd_addr), 64'd0);
      check("rst_len", 64'(tx_mrd_len), 64'd0);
      check("rst_tag", 64'(tx_mrd_tag), 64'd0);
      check("rst_alloc", 64'(pcie_tag_alloc), 64'd0);
      check("rst_alloc_tag", 64'(pcie_alloc_tag), 64'd0);
      check("rst_alloc_len", 64'(pcie_tag_alloc_len), 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      ack_mode = 1;
      for (int v = 0; v < 3; v++) begin
         model_split(vecs[v].abyte, vecs[v].len);
         start_cmd(vecs[v].abyte, vecs[v].len);
         wait_done(300);
         check("vec_n", 64'(obs_q.size()), 64'(vecs[v].n));
         for (int i = 0; i < int'(vecs[v].n); i++) begin
            if (i < obs_q.size()) begin
               check("vec_addr", 64'(obs_q[i].addr), 64'(vecs[v].eaddr[i] >> 2));
               check("vec_len", 64'(obs_q[i].len), 64'(vecs[v].elen[i]));
               check("vec_tag", 64'(obs_q[i].tag), 64'({5'b00000, vecs[v].etag[i]}));
            end
         end
         compare_model();
      end

      // Tag tracker full while parked in WAIT.
      pcie_tag_full_n = 1'b0;
      model_split(36'h2000, 1);
      start_cmd(36'h2000, 1);
      repeat (10) begin
         @(negedge clk);
         check("tagfull_no_alloc", 64'(pcie_tag_alloc), 64'd0);
         check("tagfull_no_req", 64'(tx_mrd_req), 64'd0);
      end
      @(posedge clk);
      #2;
      pcie_tag_full_n = 1'b1;
      @(negedge clk);
      check("tagfull_alloc_early", 64'(pcie_tag_alloc), 64'd0);
      @(negedge clk);
      check("tagfull_alloc_next", 64'(pcie_tag_alloc), 64'd1);
      wait_done(100);
      compare_model();

      // FIFO has a single free beat; a two-beat chunk must wait.
      rear_full_addr = 5'd16;
      front_addr     = 5'd1;
      model_split(36'h0, 2);
      start_cmd(36'h0, 2);
      repeat (6) begin
         @(negedge clk);
         check("fifo_stall", 64'(pcie_tag_alloc), 64'd0);
      end
      @(posedge clk);
      #2;
      front_addr = 5'd2;
      seen = 1'b0;
      for (int i = 0; i < 3 && !seen; i++) begin
         @(negedge clk);
         seen = pcie_tag_alloc;
      end
      check("fifo_release_alloc", 64'(seen), 64'd1);
      wait_done(100);
      compare_model();
      rear_full_addr = '0;
      front_addr     = '0;

      // Reset while a request is outstanding.
      ack_mode = 0;
      start_cmd(36'h3000, 2);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = tx_mrd_req;
      end
      check("rstreq_req_up", 64'(seen), 64'd1);
      repeat (3) begin
         @(negedge clk);
         check("rstreq_hold", 64'(tx_mrd_req), 64'd1);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rstreq_req_drop", 64'(tx_mrd_req), 64'd0);
      check("rstreq_alloc", 64'(pcie_tag_alloc), 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      ack_mode = 1;
      repeat (6) begin
         @(negedge clk);
         check("rstreq_quiet_req", 64'(tx_mrd_req), 64'd0);
         check("rstreq_quiet_alloc", 64'(pcie_tag_alloc), 64'd0);
      end
      check("rstreq_no_done", 64'(done_cnt), 64'(done_base));
      clear_all();
      mtag = 3'd0;

      // Nine single-beat fetches wrap the 3-bit tag counter.
      for (int i = 0; i < 9; i++) begin
         model_split(36'h4000 + 36'(i * 64), 1);
         start_cmd(36'h4000 + 36'(i * 64), 1);
         wait_done(100);
         if (obs_q.size() > 0) check("tag_seq", 64'(obs_q[0].tag), 64'(i % 8));
         else check("tag_seq_missing", 64'(obs_q.size()), 64'd1);
         compare_model();
      end

      rand_mode = 1'b1;
      ack_mode  = 2;
      for (int k = 0; k < 40; k++) begin
         beat = 30'($urandom);
         if ($urandom_range(0, 1) == 1) beat[5:0] = 6'(62 + $urandom_range(0, 1));
         len = $urandom_range(0, 31);
         model_split({beat, 6'b000000}, len);
         start_cmd({beat, 6'b000000}, len);
         wait_done(3000);
         compare_model();
      end
      rand_mode = 1'b0;
      ack_mode  = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
